odd_even_sort_pipe: RTL and testbench

ODD_EVEN_SORT_PIPE -- requirements
Module: odd_even_sort_pipe

---
 rtl/sort_pkg.sv | 19 +
 rtl/cmp_swap.sv | 37 +++
 rtl/odd_even_sort_pipe.sv | 149 ++++++++++++++
 tb/tb_odd_even_sort_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared constants and helpers for the odd-even transposition sorter.
// The optional index path is compiled in with SORT_INDEX_EN.
package sort_pkg;

  localparam int N_MAX = 16;
  localparam int W_MAX = 32;

  localparam logic SORT_ASC  = 1'b0;
  localparam logic SORT_DESC = 1'b1;

  // Width of a lane index, never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange of one lane pair; lo/hi are the lower/upper
// lane positions after ordering. Index pair is present with SORT_INDEX_EN.
module cmp_swap
  import sort_pkg::*;
#(
  parameter int W = 8
`ifdef SORT_INDEX_EN
  , parameter int IDXW = 3
`endif
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            desc,
`ifdef SORT_INDEX_EN
  input  logic [IDXW-1:0] a_idx,
  input  logic [IDXW-1:0] b_idx,
  output logic [IDXW-1:0] lo_idx,
  output logic [IDXW-1:0] hi_idx,
`endif
  output logic [W-1:0]    lo,
  output logic [W-1:0]    hi
);

  logic swap;

  // Strict comparison only, so equal keys keep their input order.
  assign swap = (desc == SORT_DESC) ? (a < b) : (a > b);

  assign lo = swap ? b : a;
  assign hi = swap ? a : b;

`ifdef SORT_INDEX_EN
  assign lo_idx = swap ? b_idx : a_idx;
  assign hi_idx = swap ? a_idx : b_idx;
`endif

endmodule

// File: rtl/odd_even_sort_pipe.sv
// N-stage pipelined odd-even transposition sorter with a global stall.
// Define SORT_INDEX_EN to carry original lane indices out on out_idx.
module odd_even_sort_pipe
  import sort_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8
`ifdef SORT_INDEX_EN
  , localparam int IDXW = clog2(N)
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic            in_desc,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef SORT_INDEX_EN
  output logic [N*IDXW-1:0] out_idx,
`endif
  output logic [N*W-1:0]  out_data
);

  logic [W-1:0] cur_d    [N][N];
  logic [W-1:0] nxt_d    [N][N];
  logic [W-1:0] stg_data [N][N];
  logic [N-1:0] cur_desc;
  logic [N-2:0] stg_desc;
  logic [N-1:0] stg_valid;
  logic         adv;

  assign out_valid = stg_valid[N-1];
  assign in_ready  = !(out_valid && !out_ready);
  assign adv       = in_ready;
  assign cur_desc  = {stg_desc, in_desc};

  // NOTE: every variable of an always_comb gets a value on every path, else a latch is inferred.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      cur_d[0][j] = in_data[j*W +: W];
    end
    for (int k = 1; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        cur_d[k][j] = stg_data[k-1][j];
      end
    end
  end

`ifdef SORT_INDEX_EN
  logic [IDXW-1:0] cur_i [N][N];
  logic [IDXW-1:0] nxt_i [N][N];
  logic [IDXW-1:0] stg_i [N][N];

  always_comb begin
    for (int j = 0; j < N; j++) begin
      cur_i[0][j] = IDXW'(j);
    end
    for (int k = 1; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        cur_i[k][j] = stg_i[k-1][j];
      end
    end
  end
`endif

  // Stage k pairs lanes (j, j+1) whose j has the same parity as k.
  for (genvar k = 0; k < N; k++) begin : g_stage
    for (genvar j = 0; j < N; j++) begin : g_lane
      if (((j % 2) == (k % 2)) && (j + 1 < N)) begin : g_pair
        cmp_swap #(
          .W(W)
`ifdef SORT_INDEX_EN
          , .IDXW(IDXW)
`endif
        ) u_cmp_swap (
          .a      (cur_d[k][j]),
          .b      (cur_d[k][j+1]),
          .desc   (cur_desc[k]),
`ifdef SORT_INDEX_EN
          .a_idx  (cur_i[k][j]),
          .b_idx  (cur_i[k][j+1]),
          .lo_idx (nxt_i[k][j]),
          .hi_idx (nxt_i[k][j+1]),
`endif
          .lo     (nxt_d[k][j]),
          .hi     (nxt_d[k][j+1])
        );
      end else if (!((j >= 1) && (((j - 1) % 2) == (k % 2)))) begin : g_pass
        assign nxt_d[k][j] = cur_d[k][j];
`ifdef SORT_INDEX_EN
        assign nxt_i[k][j] = cur_i[k][j];
`endif
      end
    end
  end

  // NOTE: only valid bits are reset; stage payload is always qualified by its valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= '0;
    end else if (adv) begin
      stg_valid <= {stg_valid[N-2:0], in_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      stg_desc <= cur_desc[N-2:0];
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < N; j++) begin
          stg_data[k][j] <= nxt_d[k][j];
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int j = 0; j < N; j++) begin
        out_data[j*W +: W] = stg_data[N-1][j];
      end
    end
  end

`ifdef SORT_INDEX_EN
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < N; j++) begin
          stg_i[k][j] <= nxt_i[k][j];
        end
      end
    end
  end

  always_comb begin
    out_idx = '0;
    if (out_valid) begin
      for (int j = 0; j < N; j++) begin
        out_idx[j*IDXW +: IDXW] = stg_i[N-1][j];
      end
    end
  end
`endif

endmodule

// File: tb/tb_odd_even_sort_pipe.sv
// Scoreboard bench for odd_even_sort_pipe at N=5/W=8, N=2/W=1 and N=16/W=32,
// checked against a stable insertion-sort model; SORT_INDEX_EN adds index checks.
module tb_odd_even_sort_pipe;
  import sort_pkg::*;

  localparam int N1 = 5,  W1 = 8,  I1 = clog2(N1);
  localparam int N2 = 2,  W2 = 1,  I2 = clog2(N2);
  localparam int N3 = 16, W3 = 32, I3 = clog2(N3);

  typedef struct {
    logic [511:0] data;
    logic [63:0]  idx;
    int           cyc;
    bit           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_e = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   edge_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q1[$], q2[$], q3[$];

  // DUT 1: N=5, W=8
  logic                in_valid = 1'b0, in_ready, in_desc = 1'b0, out_valid, out_ready = 1'b1;
  logic [N1*W1-1:0]    in_data = '0, out_data;
  // DUT 2: N=2, W=1
  logic                v2 = 1'b0, r2, m2 = 1'b0, ov2, or2 = 1'b1;
  logic [N2*W2-1:0]    d2 = '0, od2;
  // DUT 3: N=16, W=32
  logic                v3 = 1'b0, r3, m3 = 1'b0, ov3, or3 = 1'b1;
  logic [N3*W3-1:0]    d3 = '0, od3;
`ifdef SORT_INDEX_EN
  logic [N1*I1-1:0]    out_idx;
  logic [N2*I2-1:0]    oi2;
  logic [N3*I3-1:0]    oi3;
`endif

  odd_even_sort_pipe #(.N(N1), .W(W1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_desc(in_desc), .out_valid(out_valid), .out_ready(out_ready),
`ifdef SORT_INDEX_EN
    .out_idx(out_idx),
`endif
    .out_data(out_data));

  odd_even_sort_pipe #(.N(N2), .W(W2)) u_dut2 (
    .clk(clk), .rst(rst_e), .in_valid(v2), .in_ready(r2), .in_data(d2),
    .in_desc(m2), .out_valid(ov2), .out_ready(or2),
`ifdef SORT_INDEX_EN
    .out_idx(oi2),
`endif
    .out_data(od2));

  odd_even_sort_pipe #(.N(N3), .W(W3)) u_dut3 (
    .clk(clk), .rst(rst_e), .in_valid(v3), .in_ready(r3), .in_data(d3),
    .in_desc(m3), .out_valid(ov3), .out_ready(or3),
`ifdef SORT_INDEX_EN
    .out_idx(oi3),
`endif
    .out_data(od3));

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Reference: stable insertion sort on plain integers, recording original lane numbers.
  function automatic exp_t model(input logic [511:0] flat, input int n, input int w,
                                 input int iw, input logic desc);
    logic [31:0] v [16];
    int          ix [16];
    logic [63:0] mask;
    logic [31:0] x;
    int          j;
    exp_t        e;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < n; i++) begin
      x = 32'((flat >> (i * w)) & 512'(mask));
      j = i;
      while (j > 0 && (desc ? (v[j-1] < x) : (v[j-1] > x))) begin
        v[j]  = v[j-1];
        ix[j] = ix[j-1];
        j--;
      end
      v[j]  = x;
      ix[j] = i;
    end
    e.data = '0;
    e.idx  = '0;
    e.cyc  = 0;
    e.lat  = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.data = e.data | (512'(v[i]) << (i * w));
      e.idx  = e.idx | (64'(ix[i]) << (i * iw));
    end
    return e;
  endfunction

  // kind 0: all lanes equal, 1: lane values falling, 2: rising, else random.
  function automatic logic [511:0] gen(input int n, input int w, input int kind);
    logic [63:0]  mask, same, v;
    logic [511:0] f;
    mask = (64'd1 << w) - 64'd1;
    same = {32'h0, $urandom} & mask;
    f = '0;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       v = same;
        1:       v = 64'(n - 1 - i) & mask;
        2:       v = 64'(i) & mask;
        default: v = {32'h0, $urandom} & mask;
      endcase
      f = f | (512'(v) << (i * w));
    end
    return f;
  endfunction

  task automatic send1(input logic [N1*W1-1:0] d, input logic m, input bit use_ex,
                       input exp_t ex, input bit lat);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_desc  = m;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e = use_ex ? ex : model(512'(d), N1, W1, I1, m);
        e.cyc = cyc;
        e.lat = lat;
        q1.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    fail_now("send1_timeout", "in_ready never rose");
  endtask

  task automatic send_rand(input logic m, input bit lat);
    logic [63:0] r;
    exp_t        none;
    none = '{data: '0, idx: '0, cyc: 0, lat: 1'b0};
    r = {$urandom, $urandom};
    send1(r[N1*W1-1:0], m, 1'b0, none, lat);
  endtask

  task automatic drain1();
    for (int t = 0; t < 200 && q1.size() != 0; t++) @(posedge clk);
    #1;
    if (q1.size() != 0) fail_now("drain1_timeout", "beats never emerged");
  endtask

  // Monitor for DUT 1: compare head on every valid cycle, pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("d1_in_ready", 512'(in_ready), 512'(!(out_valid && !out_ready)));
      if (out_valid) begin
        if (q1.size() == 0) begin
          fail_now("d1_unexpected", $sformatf("out_valid with data %0h", out_data));
        end else begin
          check("d1_data", 512'(out_data), q1[0].data);
`ifdef SORT_INDEX_EN
          check("d1_idx", 512'(out_idx), 512'(q1[0].idx));
`endif
          if (q1[0].lat) check("d1_latency", 512'(cyc), 512'(q1[0].cyc + N1));
          if (out_ready) void'(q1.pop_front());
        end
      end else begin
        check("d1_zero", 512'(out_data), '0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_e) begin
      check("d2_in_ready", 512'(r2), 512'(1));
      if (ov2) begin
        if (q2.size() == 0) begin
          fail_now("d2_unexpected", $sformatf("out_valid with data %0h", od2));
        end else begin
          check("d2_data", 512'(od2), q2[0].data);
`ifdef SORT_INDEX_EN
          check("d2_idx", 512'(oi2), 512'(q2[0].idx));
`endif
          check("d2_latency", 512'(cyc), 512'(q2[0].cyc + N2));
          void'(q2.pop_front());
        end
      end
      if (ov3) begin
        if (q3.size() == 0) begin
          fail_now("d3_unexpected", $sformatf("out_valid with data %0h", od3));
        end else begin
          check("d3_data", 512'(od3), q3[0].data);
`ifdef SORT_INDEX_EN
          check("d3_idx", 512'(oi3), 512'(q3[0].idx));
`endif
          check("d3_latency", 512'(cyc), 512'(q3[0].cyc + N3));
          void'(q3.pop_front());
        end
      end
    end
  end

  // Edge-size builds: all-equal, reverse-sorted, already-sorted and random beats.
  initial begin
    exp_t         e;
    logic [511:0] g;
    int           kind;
    logic         m;
    repeat (2) @(posedge clk);
    #1 rst_e = 1'b0;
    for (int b = 0; b < 14; b++) begin
      kind = (b < 2) ? 0 : (b == 2) ? 1 : (b == 3) ? 2 : (b == 4) ? 1 : 3;
      m    = (b == 2) ? 1'b0 : (b == 3 || b == 4) ? 1'b1 : logic'(b % 2);
      g  = gen(N2, W2, kind);
      d2 = g[N2*W2-1:0];
      d3 = gen(N3, W3, kind);
      m2 = m;
      m3 = m;
      v2 = 1'b1;
      v3 = 1'b1;
      @(negedge clk);
      if (r2) begin
        e = model(512'(d2), N2, W2, I2, m2);
        e.cyc = cyc;
        q2.push_back(e);
      end
      if (r3) begin
        e = model(d3, N3, W3, I3, m3);
        e.cyc = cyc;
        q3.push_back(e);
      end
      @(posedge clk);
      #1;
      if (b > 5 && $urandom_range(0, 2) == 0) begin
        v2 = 1'b0;
        v3 = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    v2 = 1'b0;
    v3 = 1'b0;
    for (int t = 0; t < 100 && (q2.size() != 0 || q3.size() != 0); t++) @(posedge clk);
    edge_done = 1'b1;
  end

  initial begin
    exp_t ex;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_out_valid", 512'(out_valid), '0);
    check("reset_out_data", 512'(out_data), '0);
    check("reset_in_ready", 512'(in_ready), 512'(1));
`ifdef SORT_INDEX_EN
    check("reset_out_idx", 512'(out_idx), '0);
`endif
    @(posedge clk);
    #1;

    // Directed beats with hand-derived results.
    ex = '{data: 512'(40'hFF_80_37_05_05), idx: 64'({3'd2, 3'd4, 3'd0, 3'd3, 3'd1}), cyc: 0, lat: 1'b0};
    send1(40'h80_05_FF_05_37, SORT_ASC, 1'b1, ex, 1'b1);
    ex = '{data: 512'(40'h05_05_37_80_FF), idx: 64'({3'd3, 3'd1, 3'd0, 3'd4, 3'd2}), cyc: 0, lat: 1'b0};
    send1(40'h80_05_FF_05_37, SORT_DESC, 1'b1, ex, 1'b1);

    // Back-to-back random beats alternating mode.
    for (int i = 0; i < 20; i++) send_rand(logic'(i % 2), 1'b1);
    drain1();

    // Backpressure: hold out_ready low for three cycles while beats are valid.
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand(logic'($urandom_range(0, 1)), 1'b0);
      end
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_out_valid", 512'(out_valid), 512'(1));
        check("stall_in_ready", 512'(in_ready), '0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain1();

    // Reset with three beats in flight; the beat offered alongside rst is dropped too.
    for (int i = 0; i < 3; i++) send_rand(logic'(i % 2), 1'b0);
    in_valid = 1'b1;
    in_data  = 40'h01_02_03_04_05;
    rst      = 1'b1;
    q1.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 512'(out_valid), '0);
    check("rst_out_data", 512'(out_data), '0);
    repeat (12) @(posedge clk);
    #1;

    // Recovery after reset.
    for (int i = 0; i < 3; i++) send_rand(logic'(i % 2), 1'b1);
    drain1();

    for (int t = 0; t < 500 && !edge_done; t++) @(posedge clk);
    if (!edge_done) fail_now("edge_timeout", "edge-size beats never drained");
    @(negedge clk);
    check("q1_empty", 512'(q1.size()), '0);
    check("q2_empty", 512'(q2.size()), '0);
    check("q3_empty", 512'(q3.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
